// File: rtl/id_ex_pkg.sv
// Shared constants for the ID/EX pipeline register: control-word layout and NOP encodings.
package id_ex_pkg;

  localparam int CTRL_W    = 6;
  localparam int REGADDR_W = 5;

  // Bit positions within {regwrite, memread, memwrite, memtoreg, alusrc, branch}
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_BRANCH   = 0;

  localparam logic [3:0]        ALUOP_NOP = 4'b0000;
  localparam logic [3:0]        FUNCT_NOP = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_NOP  = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check between the load currently in EX and the instruction in ID.
module load_use_detect
  import id_ex_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_memread,
  input  logic [REGADDR_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REGADDR_W-1:0] id_rs1,
  input  logic [REGADDR_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  output logic                 ld_stall_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 destinations never produce a value worth waiting for
  assign ld_stall_o = ex_valid && ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit) && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and stall handling.
// Optional saturating bubble counter enabled by defining ID_EX_PERF_EN.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid_i,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [XLEN-1:0]      id_rs1_data_i,
  input  logic [XLEN-1:0]      id_rs2_data_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic [REGADDR_W-1:0] id_rs1_i,
  input  logic [REGADDR_W-1:0] id_rs2_i,
  input  logic [REGADDR_W-1:0] id_rd_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [3:0]           id_ALUOp_i,
  input  logic [3:0]           id_funct_i,
  input  logic [CTRL_W-1:0]    id_ctrl_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 ld_stall_o,
  output logic                 ex_valid_o,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [XLEN-1:0]      ex_rs1_data_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic [REGADDR_W-1:0] ex_rs1_o,
  output logic [REGADDR_W-1:0] ex_rs2_o,
  output logic [REGADDR_W-1:0] ex_rd_o,
  output logic [3:0]           ex_ALUOp_o,
  output logic [3:0]           ex_funct_o,
  output logic [CTRL_W-1:0]    ex_ctrl_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]          bubble_cnt_o
`endif
);

  logic                 vld_p1;
  logic [XLEN-1:0]      pc_p1;
  logic [XLEN-1:0]      rs1_data_p1;
  logic [XLEN-1:0]      rs2_data_p1;
  logic [XLEN-1:0]      imm_p1;
  logic [REGADDR_W-1:0] rs1_p1;
  logic [REGADDR_W-1:0] rs2_p1;
  logic [REGADDR_W-1:0] rd_p1;
  logic [3:0]           aluop_p1;
  logic [3:0]           funct_p1;
  logic [CTRL_W-1:0]    ctrl_p1;

  logic ld_stall;
  logic load_nop;

  load_use_detect u_load_use_detect (
    .ex_valid   (vld_p1),
    .ex_memread (ctrl_p1[CTRL_MEMREAD]),
    .ex_rd      (rd_p1),
    .id_valid   (id_valid_i),
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .id_use_rs1 (id_use_rs1_i),
    .id_use_rs2 (id_use_rs2_i),
    .ld_stall_o (ld_stall)
  );

  // A bubble is inserted by a flush, or by a hazard when the stage is not held
  assign load_nop = flush_i || (!stall_i && ld_stall);

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      aluop_p1    <= ALUOP_NOP;
      funct_p1    <= FUNCT_NOP;
      ctrl_p1     <= CTRL_NOP;
    end else if (load_nop) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      aluop_p1    <= ALUOP_NOP;
      funct_p1    <= FUNCT_NOP;
      ctrl_p1     <= CTRL_NOP;
    end else if (!stall_i) begin
      vld_p1      <= id_valid_i;
      pc_p1       <= id_pc_i;
      rs1_data_p1 <= id_rs1_data_i;
      rs2_data_p1 <= id_rs2_data_i;
      imm_p1      <= id_imm_i;
      rs1_p1      <= id_rs1_i;
      rs2_p1      <= id_rs2_i;
      // An empty decode slot travels with NOP control so it can never write state
      rd_p1       <= id_valid_i ? id_rd_i    : '0;
      aluop_p1    <= id_valid_i ? id_ALUOp_i : ALUOP_NOP;
      funct_p1    <= id_valid_i ? id_funct_i : FUNCT_NOP;
      ctrl_p1     <= id_valid_i ? id_ctrl_i  : CTRL_NOP;
    end
  end

  assign ld_stall_o    = ld_stall;
  assign ex_valid_o    = vld_p1;
  assign ex_pc_o       = pc_p1;
  assign ex_rs1_data_o = rs1_data_p1;
  assign ex_rs2_data_o = rs2_data_p1;
  assign ex_imm_o      = imm_p1;
  assign ex_rs1_o      = rs1_p1;
  assign ex_rs2_o      = rs2_p1;
  assign ex_rd_o       = rd_p1;
  assign ex_ALUOp_o    = aluop_p1;
  assign ex_funct_o    = funct_p1;
  assign ex_ctrl_o     = ctrl_p1;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_p1 <= '0;
    end else if (load_nop) begin
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign bubble_cnt_o = bubble_cnt_p1;
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the RV32I pipelined CPU, with integrated load-use hazard detection. Captures decoded operands and control from the decode stage. Drives the EX stage, including `ALUOp`/`funct` into the ALU control block. Applies stall, flush and bubble insertion so that EX only ever sees either a valid instruction or an architecturally harmless NOP.

## Interface
Parameters:
- `XLEN`, 32: operand/PC width.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `id_valid_i`  in  1: decode slot holds a real instruction.
- `id_pc_i`, `id_rs1_data_i`, `id_rs2_data_i`, `id_imm_i`  in  XLEN each: PC, register-file read data, sign-extended immediate.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  5 each: register addresses.
- `id_use_rs1_i`, `id_use_rs2_i`  in  1 each: instruction actually reads rs1/rs2.
- `id_ALUOp_i`  in  4: ALU operation class from main control.
- `id_funct_i`  in  4: {instr[30], funct3}.
- `id_ctrl_i`  in  6: {regwrite, memread, memwrite, memtoreg, alusrc, branch}.
- `stall_i`  in  1: downstream hold (e.g. memory wait).
- `flush_i`  in  1: taken branch/jump resolved in EX; kill the decode instruction.
- `ld_stall_o`  out  1: load-use hazard; IF and IF/ID must hold this cycle.
- `ex_valid_o`, `ex_pc_o`, `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o`, `ex_rs1_o`, `ex_rs2_o`, `ex_rd_o`, `ex_ALUOp_o`, `ex_funct_o`, `ex_ctrl_o`  out: registered copies of the matching `id_*` inputs, same widths.
- `bubble_cnt_o`  out  32: inserted-bubble count. Present only with `ID_EX_PERF_EN`.

## Operation
- Hazard (combinational): `ld_stall_o = ex_valid_o & ex_ctrl_o.memread & (ex_rd_o != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_o) | (id_use_rs2_i & id_rs2_i == ex_rd_o)) & id_valid_i`.
- `ld_stall_o` is not gated by `flush_i` or `stall_i`. Upstream applies its own priority.
- Register update each rising edge, priority highest first:
  1. `flush_i`: load NOP.
  2. `stall_i`: hold all EX fields unchanged.
  3. `ld_stall_o`: load NOP. The decode instruction is retained upstream and re-presented.
  4. Otherwise: capture all `id_*` fields. `ex_valid_o <= id_valid_i`.
- NOP: `ex_valid_o=0`, `ex_ctrl_o=0`, `ex_rd_o=0`, `ex_ALUOp_o=0000`, `ex_funct_o=0000`. Data, PC and address fields are zeroed.
- When `id_valid_i=0` and the normal capture path applies, the control fields are still forced to the NOP encoding. Invalid slots never write state.

## Timing
- Latency: 1 cycle, ID to EX.
- `ld_stall_o` is combinational from the current EX registers and the ID inputs. No registered delay.
- Reset (asynchronous assert, synchronous release): every `ex_*` output is 0, `ex_valid_o=0`, and `bubble_cnt_o=0`. Consequently `ld_stall_o=0`.
- Reset asserted mid-stall or mid-flush: all state is cleared immediately, and no pending bubble survives.
- Load-use sequence: a load in EX at cycle N with a dependent instruction in ID gives `ld_stall_o=1` in cycle N. The bubble is in EX at N+1, where `ld_stall_o=0`. The dependent instruction enters EX at N+2.
- `flush_i` and `stall_i` together: the flush wins and a NOP is loaded.
- `ex_rd_o=0` never raises the hazard. x0 loads are ignored.

## Configuration
- `ID_EX_PERF_EN` defined: a 32-bit `bubble_cnt_o` increments on every edge where a NOP is loaded by `flush_i` or `ld_stall_o`. It does not increment on `stall_i` holds. The counter saturates at 0xFFFFFFFF and is cleared by `reset`.
- `ID_EX_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `id_ex_pkg`: `CTRL_W=6`, control bit indices (`CTRL_REGWRITE` … `CTRL_BRANCH`), `ALUOP_NOP=4'b0000`, `FUNCT_NOP=4'b0000`, `REGADDR_W=5`.
- Sub-module `load_use_detect`: purely combinational. Inputs are the EX memread, EX rd, EX valid, and the ID rs1/rs2/use/valid signals. Output is `ld_stall_o`.
- The top level holds the registers, the priority mux and the optional counter.

## Test plan
- Reset asserted mid-cycle with the EX fields loaded → every output reads 0 immediately, before the next clock edge.
- ADDI x5,x1,7 in ID (`ALUOp=0001`, `funct=0000`, imm=7), no control → next cycle `ex_ALUOp_o=0001`, `ex_imm_o=7`, `ex_rd_o=5`, `ex_valid_o=1`.
- LW x3 in EX, then ID has SUB x4,x3,x2 (`id_use_rs1_i=1`, `rs1=3`) → `ld_stall_o=1`. The next cycle has the NOP in EX (`ex_ctrl_o=0`). The cycle after has the SUB in EX (`ALUOp=0100`, `funct=1000`).
- LW x0 in EX with ID rs1=0 → `ld_stall_o=0`. LW x3 in EX with ID `use_rs2=0`, `rs2=3` → `ld_stall_o=0`.
- `stall_i=1` for 3 cycles while the ID inputs change → the EX outputs stay constant. Then `flush_i=1` together with `stall_i=1` → NOP in EX.
- With `ID_EX_PERF_EN`: 2 flushes plus 1 load-use bubble plus 4 stall cycles → `bubble_cnt_o=3`.
